// File: rtl/id_stage_ctrl.sv
// rtl/id_stage_ctrl.sv - decode-stage controller: IF/ID register, opcode decode, ID/EX register, load-use/stall/flush sequencing.
// Optional macro ID_PERF_CNT_EN adds saturating perf_bubbles/perf_flushes counters.
module id_stage_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h00000013)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            ex_stall,
  input  logic            ex_flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_inst,
  output logic [XLEN-1:0] ex_pc,
  output logic [2:0]      ImmSel,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_wen,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_alu_imm,
  output logic            ex_illegal
`ifdef ID_PERF_CNT_EN
  ,
  output logic [15:0]     perf_bubbles,
  output logic [15:0]     perf_flushes
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {RUN, BUBBLE} state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [2:0]      imm_sel;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_wen;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_imm;
    logic            illegal;
  } idex_t;

  state_t          state_q, state_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_inst_q, ifid_inst_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  idex_t           idex_q, idex_d;
  idex_t           idex_bubble, idex_dec;

  logic [6:0] opcode;
  logic       use_rs1, use_rs2;
  logic       hazard;

  assign opcode = ifid_inst_q[6:0];

  always_comb begin
    idex_bubble      = '0;
    idex_bubble.inst = NOP_INST;

    idex_dec         = '0;
    idex_dec.valid   = ifid_valid_q;
    idex_dec.inst    = ifid_inst_q;
    idex_dec.pc      = ifid_pc_q;
    idex_dec.rs1     = ifid_inst_q[19:15];
    idex_dec.rs2     = ifid_inst_q[24:20];
    idex_dec.rd      = ifid_inst_q[11:7];
    idex_dec.imm_sel = 3'd7;
    idex_dec.reg_wen = 1'b1;
    use_rs1          = 1'b0;
    use_rs2          = 1'b0;
    case (opcode)
      OP_R:      begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IMM:    begin idex_dec.imm_sel = 3'd0; use_rs1 = 1'b1; end
      OP_LOAD:   begin idex_dec.imm_sel = 3'd0; use_rs1 = 1'b1; idex_dec.mem_read = 1'b1; end
      OP_JALR:   begin idex_dec.imm_sel = 3'd0; use_rs1 = 1'b1; idex_dec.jump = 1'b1; end
      OP_STORE:  begin
        idex_dec.imm_sel   = 3'd1;
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
        idex_dec.mem_write = 1'b1;
        idex_dec.reg_wen   = 1'b0;
      end
      OP_BRANCH: begin
        idex_dec.imm_sel = 3'd2;
        use_rs1          = 1'b1;
        use_rs2          = 1'b1;
        idex_dec.branch  = 1'b1;
        idex_dec.reg_wen = 1'b0;
      end
      OP_LUI, OP_AUIPC: idex_dec.imm_sel = 3'd3;
      OP_JAL:    begin idex_dec.imm_sel = 3'd4; idex_dec.jump = 1'b1; end
      default:   begin idex_dec.illegal = 1'b1; idex_dec.reg_wen = 1'b0; end
    endcase
    idex_dec.alu_imm = (idex_dec.imm_sel == 3'd0) || (idex_dec.imm_sel == 3'd3);
    if (idex_dec.rd == 5'd0) idex_dec.reg_wen = 1'b0;
  end

  // Load-use: the load in ID/EX writes a register the IF/ID instruction reads.
  assign hazard = (state_q == RUN) && ifid_valid_q && idex_q.valid && idex_q.mem_read &&
                  (idex_q.rd != 5'd0) &&
                  ((use_rs1 && (ifid_inst_q[19:15] == idex_q.rd)) ||
                   (use_rs2 && (ifid_inst_q[24:20] == idex_q.rd)));

  assign id_ready = !ex_flush && !ex_stall && !hazard;

  always_comb begin
    state_d      = state_q;
    ifid_valid_d = ifid_valid_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    idex_d       = idex_q;
    if (ex_flush) begin
      state_d      = RUN;
      ifid_valid_d = 1'b0;
      ifid_inst_d  = NOP_INST;
      ifid_pc_d    = '0;
      idex_d       = idex_bubble;
    end else if (ex_stall) begin
      state_d = state_q;
    end else if (hazard) begin
      state_d = BUBBLE;
      idex_d  = idex_bubble;
    end else begin
      state_d      = RUN;
      idex_d       = ifid_valid_q ? idex_dec : idex_bubble;
      ifid_valid_d = if_valid;
      ifid_inst_d  = if_inst;
      ifid_pc_d    = if_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= NOP_INST;
      ifid_pc_q    <= '0;
      idex_q       <= idex_bubble;
    end else begin
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      idex_q       <= idex_d;
    end
  end

  assign ex_valid     = idex_q.valid;
  assign ex_inst      = idex_q.inst;
  assign ex_pc        = idex_q.pc;
  assign ImmSel       = idex_q.imm_sel;
  assign ex_rs1       = idex_q.rs1;
  assign ex_rs2       = idex_q.rs2;
  assign ex_rd        = idex_q.rd;
  assign ex_reg_wen   = idex_q.reg_wen;
  assign ex_mem_read  = idex_q.mem_read;
  assign ex_mem_write = idex_q.mem_write;
  assign ex_branch    = idex_q.branch;
  assign ex_jump      = idex_q.jump;
  assign ex_alu_imm   = idex_q.alu_imm;
  assign ex_illegal   = idex_q.illegal;

`ifdef ID_PERF_CNT_EN
  logic [15:0] perf_bubbles_q, perf_flushes_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (ex_flush && (perf_flushes_q != 16'hFFFF))
        perf_flushes_q <= perf_flushes_q + 16'd1;
      if (!ex_flush && !ex_stall && hazard && (perf_bubbles_q != 16'hFFFF))
        perf_bubbles_q <= perf_bubbles_q + 16'd1;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule
